// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: scoreboard-based operand forwarding and load-use stall for the 8-bit-ISA pipeline.
// Optional HAZ_PERF_CNT_EN adds a saturating stall_cnt output.
module fwd_hazard_unit #(
   parameter int REG_AW = 3,
   parameter int DEPTH = 2,
   localparam int INSTR_W = 2 + 2 * REG_AW,
   localparam int SEL_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               issue_valid,
   input  logic [INSTR_W-1:0] issue_instr,
   input  logic               flush,
   output logic               stall,
   output logic               ex_valid,
   output logic [INSTR_W-1:0] ex_instr,
   output logic [SEL_W-1:0]   fwd_sel_a,
   output logic [SEL_W-1:0]   fwd_sel_b
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);
   logic [1:0] i_opc, ex_opc;
   logic [REG_AW-1:0] i_rd, i_rs, ex_rd, ex_rs;
   logic i_use_a, i_use_b, ex_use_a, ex_use_b;
   logic [DEPTH:1] s_valid;
   logic [DEPTH:1][REG_AW-1:0] s_rd;
   logic [DEPTH:1][1:0] s_opc;
   assign {i_opc, i_rd, i_rs} = issue_instr;
   assign {ex_opc, ex_rd, ex_rs} = ex_instr;
   assign i_use_a = i_opc[0];
   assign i_use_b = i_opc != 2'b00;
   assign ex_use_a = ex_opc[0];
   assign ex_use_b = ex_opc != 2'b00;
   assign stall = issue_valid && ex_valid && ex_opc == 2'b10 && !flush &&
                  ((i_use_a && i_rd == ex_rd) || (i_use_b && i_rs == ex_rd));
   // Scan oldest to youngest so the youngest qualifying writer overrides.
   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (ex_valid && s_valid[k] && s_opc[k] != 2'b11 && (s_opc[k] != 2'b10 || k >= 2)) begin
            if (ex_use_a && s_rd[k] == ex_rd) fwd_sel_a = SEL_W'(k);
            if (ex_use_b && s_rd[k] == ex_rs) fwd_sel_b = SEL_W'(k);
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_instr <= '0;
         s_valid  <= '0;
         s_rd     <= '0;
         s_opc    <= '0;
      end else begin
         ex_valid <= issue_valid && !stall && !flush;
         ex_instr <= (stall || flush) ? '0 : issue_instr;
         s_valid  <= {s_valid[DEPTH-1:1], ex_valid};
         s_rd     <= {s_rd[DEPTH-1:1], ex_rd};
         s_opc    <= {s_opc[DEPTH-1:1], ex_opc};
      end
   end
`ifdef HAZ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt <= '0;
      else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule
